alu_ctrl_seq: RTL

Registered, parametrised ALU control unit for the core's execute stage. Decodes `alu_op` plus the R-type `funct` field into an ALU control code behind a valid/ready handshake. Holds multi-cycle operations (MUL/DIV) for a programmable number of cycles, back-pressuring the decode stage while the ALU iterates.

---
 rtl/alu_ctrl_pkg.sv | 41 ++++
 rtl/alu_ctrl_dec.sv | 65 ++++++
 rtl/alu_ctrl_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control unit: control encodings, funct
// codes, alu_op codes and FSM state encoding.
package alu_ctrl_pkg;

    // ALU control encodings (4-bit core code, zero-extended to CTRL_W)
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLL = 4'b0011;
    localparam logic [3:0] CTRL_SRL = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_MUL = 4'b1000;
    localparam logic [3:0] CTRL_DIV = 4'b1001;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // R-type funct codes (low 6 bits of the funct field)
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    // alu_op codes from the main decoder
    localparam logic [1:0] OP_LDST  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_SLTI  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_VALID = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of alu_op/funct into ALU control code, illegal and
// multi-cycle flags. MUL/DIV are only recognised when ALU_CTRL_MULDIV_EN is
// defined; otherwise they fall into the illegal path.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               illegal,
    output logic               multi
);

    logic [3:0] code;
    logic       funct_hi_set;

    // Any set bit above the decoded 6 makes the R-type op illegal
    assign funct_hi_set = ((funct >> 6) != '0);

    // Map alu_op/funct to the 4-bit control code and flags
    always_comb begin
        code    = CTRL_ADD;
        illegal = 1'b0;
        multi   = 1'b0;
        case (alu_op)
            OP_LDST:   code = CTRL_ADD;
            OP_BRANCH: code = CTRL_SUB;
            OP_SLTI:   code = CTRL_SLT;
            OP_RTYPE: begin
                if (funct_hi_set) begin
                    illegal = 1'b1;
                end else begin
                    case (funct[5:0])
                        FUNCT_ADD: code = CTRL_ADD;
                        FUNCT_SUB: code = CTRL_SUB;
                        FUNCT_AND: code = CTRL_AND;
                        FUNCT_OR:  code = CTRL_OR;
                        FUNCT_NOR: code = CTRL_NOR;
                        FUNCT_SLT: code = CTRL_SLT;
                        FUNCT_SLL: code = CTRL_SLL;
                        FUNCT_SRL: code = CTRL_SRL;
`ifdef ALU_CTRL_MULDIV_EN
                        FUNCT_MUL: begin
                            code  = CTRL_MUL;
                            multi = 1'b1;
                        end
                        FUNCT_DIV: begin
                            code  = CTRL_DIV;
                            multi = 1'b1;
                        end
`endif
                        default:   illegal = 1'b1;
                    endcase
                end
            end
            default:   code = CTRL_ADD;
        endcase
    end

    assign ctrl = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit with valid/ready handshake on both sides.
// Optional feature macro: ALU_CTRL_MULDIV_EN -- enables MUL/DIV decode and
// the WAIT state with its down-counter; without it busy is 0 and the
// decoder never flags multi, so the multi register stays at 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no op held; in_ready high
// ST_VALID | decoded op presented to the ALU; held until out_ready
// ST_WAIT  | MUL/DIV iterating; counter runs down to 0, then ST_VALID
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               illegal,
    output logic               multi,
    output logic               busy
);

    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("alu_ctrl_seq: CTRL_W must be at least 4");
    end
    if (FUNCT_W < 6) begin : g_bad_funct_w
        $error("alu_ctrl_seq: FUNCT_W must be at least 6");
    end
    if (MUL_CYCLES < 1 || MUL_CYCLES > 255) begin : g_bad_mul
        $error("alu_ctrl_seq: MUL_CYCLES out of range 1..255");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div
        $error("alu_ctrl_seq: DIV_CYCLES out of range 1..255");
    end

    state_t             state, state_nxt;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic               dec_illegal;
    logic               dec_multi;
    logic               accept;

`ifdef ALU_CTRL_MULDIV_EN
    // Counter loads cycles-1 so WAIT lasts exactly the configured count
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
    logic [7:0] cnt, cnt_nxt;
`endif

    alu_ctrl_dec #(
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .multi   (dec_multi)
    );

    assign in_ready  = (state == ST_IDLE) || ((state == ST_VALID) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_VALID);
`ifdef ALU_CTRL_MULDIV_EN
    assign busy      = (state == ST_WAIT);
`else
    assign busy      = 1'b0;
`endif

    // Next-state selection and counter update
    always_comb begin
        state_nxt = state;
`ifdef ALU_CTRL_MULDIV_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            ST_IDLE, ST_VALID: begin
                if (accept) begin
`ifdef ALU_CTRL_MULDIV_EN
                    if (dec_multi) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = (dec_ctrl[3:0] == CTRL_MUL) ? MUL_LOAD : DIV_LOAD;
                    end else begin
                        state_nxt = ST_VALID;
                    end
`else
                    state_nxt = ST_VALID;
`endif
                end else if ((state == ST_VALID) && out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef ALU_CTRL_MULDIV_EN
            ST_WAIT: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_VALID;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter and output registers; outputs load only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            alu_ctrl <= '0;
            illegal  <= 1'b0;
            multi    <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
            cnt      <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
`ifdef ALU_CTRL_MULDIV_EN
            cnt   <= cnt_nxt;
`endif
            if (accept) begin
                alu_ctrl <= dec_ctrl;
                illegal  <= dec_illegal;
                multi    <= dec_multi;
            end
        end
    end

endmodule
